board_drop_ctrl: RTL and testbench
==================================

# board_drop_ctrl

Board-state owner and move sequencer for the Connect Four datapath, directly upstream of the win register decoder. Accepts a column drop request, scans that column for the lowest empty row, and writes the piece into the 42-bit occupancy and player boards. It then presents `location`, `height`, `player` and both boards to the decoder/win evaluator and waits for its verdict. From that verdict it advances the turn, or ends the game as a win or a draw.

## Interface
- No parameters. Board geometry is fixed by constants in the shared package.
- `clk` in 1: single clock. All state changes on the rising edge.
- `reset` in 1: synchronous, active-high.
- `new_game` in 1: synchronous clear. Identical effect to `reset`.
- `drop_req` in 1: level request. Sampled only in IDLE.
- `drop_col` in 3: requested column, 0..6. Value 7 is invalid.
- `win_valid` in 1: win evaluator verdict is valid this cycle.
- `win_in` in 1: verdict. 1 = the last move completed four in a row.
- `player_register` out 42: cell owner bit, 1 = player 1. Meaningful only where `onoff_register` = 1.
- `onoff_register` out 42: cell occupied.
- `location` out 3: column of the last placed piece.
- `height` out 3: row of the last placed piece. Row 0 = bottom.
- `player` out 1: owner of the last placed piece.
- `turn` out 1: player to move next.
- `check_valid` out 1: high throughout CHECK. Boards and location/height are stable.
- `drop_ack` out 1: one-cycle pulse when a move is fully accepted and judged.
- `drop_err` out 1: one-cycle pulse when a request is rejected.
- `game_over` out 1: sticky until reset or `new_game`.
- `winner` out 1: valid when `game_over` and not `draw`.
- `draw` out 1: sticky. Board full with no win.
- `move_count` out 6: pieces placed, 0..42.

## Operation
- Cell index = 6*col + row. Column c occupies bits 6c..6c+5, bit 6c is the bottom row.
- Reset values: all outputs 0, FSM in IDLE. `turn` = 0, so player 0 moves first.
- FSM states: IDLE, SCAN, WRITE, CHECK, DONE.
- IDLE
  - `drop_req`=1 with `drop_col` ≤ 6: latch the column, clear the row counter, go to SCAN.
  - `drop_col`=7: pulse `drop_err`, stay in IDLE.
- SCAN: examine `onoff_register[6*col+row]`, one row per cycle, starting at row 0.
  - Cell empty: latch row, go to WRITE.
  - Occupied and row=5: column full. Pulse `drop_err`, go to IDLE. Turn, boards and count are unchanged.
  - Otherwise: row+1.
- WRITE
  - Set the onoff bit. Set the player bit to `turn`.
  - `location`←col, `height`←row, `player`←`turn`, `move_count`+1.
  - Go to CHECK.
- CHECK: hold `check_valid`=1 and wait for `win_valid`. No timeout.
  - `win_in`=1: `game_over`=1, `winner`=`player`. Go to DONE.
  - Else if `move_count`=42: `game_over`=1, `draw`=1. Go to DONE.
  - Else: toggle `turn`, go to IDLE.
  - All three exits pulse `drop_ack` once.
- DONE: `drop_req` pulses `drop_err` and nothing else changes. Leave only via `reset` or `new_game`.
- `drop_req` outside IDLE is ignored, not queued.
- `new_game` or `reset` in any state, including mid-SCAN or CHECK: clear all boards, counters and flags, go to IDLE. A partial move leaves no trace.
- `move_count` never wraps. The 42 check occurs before any further write is possible.

## Timing
- `drop_req` sampled at edge T: SCAN occupies T+1..T+1+r when landing at row r.
- WRITE occurs at T+2+r. New boards are visible at T+3+r, the first CHECK cycle.
- `win_valid` is honoured from the first CHECK cycle onward.
- If `win_valid` is seen at cycle K, then at K+1: `drop_ack`=1, and the updated `turn`/`game_over`/`draw`/`winner` are visible.
- Minimum request-to-ack latency: 4 cycles (row 0, immediate verdict).
- Full column: `drop_err` at T+7 (6 SCAN cycles). Invalid column: `drop_err` at T+1.
- All outputs are registered. There is no combinational input-to-output path.

## Structure
- `connect4_pkg` holds:
  - constants `COLS`=7, `ROWS`=6, `BOARD_BITS`=42;
  - the FSM state enum;
  - function `cell_idx(col,row)`;
  - the `MAX_MOVES`=42 constant.
  - The decoder and evaluator share the same package.
- Single flat module: the FSM and both board registers live together. No sub-module is warranted.

## Test plan
- Reset, drop col 3, `win_valid`=1 with `win_in`=0 on the first CHECK cycle:
  - onoff bit 18=1, player bit 18=0;
  - `height`=0, `location`=3;
  - `drop_ack` 4 cycles after the request, then `turn`=1, `move_count`=1.
- Seven drops into col 0, all verdicts no-win:
  - drops 1–6 fill bits 0..5 with alternating owners 0,1,0,1,0,1;
  - drop 7 gives `drop_err` after 6 SCAN cycles; boards, `turn` and `move_count`=6 are unchanged.
- `drop_col`=7 → `drop_err` the next cycle, no state change.
- Verdict `win_in`=1 on a player-1 move → `game_over`=1, `winner`=1. A subsequent `drop_req` gives only `drop_err`.
- Fill the board with 42 no-win moves → after the last ack, `draw`=1, `game_over`=1, `move_count`=42.
- Assert `new_game` during SCAN of row 3 → next cycle all boards are 0, `move_count`=0, `turn`=0, IDLE. The following drop lands at row 0.

Source files
------------

// File: rtl/connect4_pkg.sv
// rtl/connect4_pkg.sv - shared Connect Four board geometry, FSM states and cell indexing
package connect4_pkg;

   localparam int COLS       = 7;
   localparam int ROWS       = 6;
   localparam int BOARD_BITS = 42;

   localparam logic [5:0] MAX_MOVES   = 6'd42;
   localparam logic [2:0] TOP_ROW     = 3'(ROWS - 1);
   localparam logic [2:0] INVALID_COL = 3'd7;

   typedef enum logic [2:0] {
      IDLE,
      SCAN,
      WRITE,
      CHECK,
      DONE
   } state_t;

   // Column-major layout: each column is a contiguous 6-bit field, bottom row first.
   function automatic logic [5:0] cell_idx(input logic [2:0] col, input logic [2:0] row);
      return 6'(col) * 6'(ROWS) + 6'(row);
   endfunction

endpackage

// File: rtl/board_drop_ctrl.sv
// rtl/board_drop_ctrl.sv - board-state owner and move sequencer feeding the win evaluator
module board_drop_ctrl
   import connect4_pkg::*;
(
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  new_game,
   input  logic                  drop_req,
   input  logic [2:0]            drop_col,
   input  logic                  win_valid,
   input  logic                  win_in,
   output logic [BOARD_BITS-1:0] player_register,
   output logic [BOARD_BITS-1:0] onoff_register,
   output logic [2:0]            location,
   output logic [2:0]            height,
   output logic                  player,
   output logic                  turn,
   output logic                  check_valid,
   output logic                  drop_ack,
   output logic                  drop_err,
   output logic                  game_over,
   output logic                  winner,
   output logic                  draw,
   output logic [5:0]            move_count
);

   state_t     state;
   state_t     state_nxt;
   logic [2:0] col_q;
   logic [2:0] row_q;
   logic       err_nxt;
   logic       ack_nxt;
   logic       cell_full;

   assign cell_full = onoff_register[cell_idx(col_q, row_q)];

   always_comb begin
      state_nxt = state;
      err_nxt   = 1'b0;
      ack_nxt   = 1'b0;
      case (state)
         IDLE: begin
            if (drop_req) begin
               if (drop_col == INVALID_COL) err_nxt = 1'b1;
               else                         state_nxt = SCAN;
            end
         end
         SCAN: begin
            if (!cell_full) begin
               state_nxt = WRITE;
            end else if (row_q == TOP_ROW) begin
               err_nxt   = 1'b1;
               state_nxt = IDLE;
            end
         end
         WRITE: state_nxt = CHECK;
         CHECK: begin
            if (win_valid) begin
               ack_nxt   = 1'b1;
               state_nxt = (win_in || move_count == MAX_MOVES) ? DONE : IDLE;
            end
         end
         DONE: begin
            if (drop_req) err_nxt = 1'b1;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset || new_game) begin
         state           <= IDLE;
         col_q           <= '0;
         row_q           <= '0;
         player_register <= '0;
         onoff_register  <= '0;
         location        <= '0;
         height          <= '0;
         player          <= 1'b0;
         turn            <= 1'b0;
         check_valid     <= 1'b0;
         drop_ack        <= 1'b0;
         drop_err        <= 1'b0;
         game_over       <= 1'b0;
         winner          <= 1'b0;
         draw            <= 1'b0;
         move_count      <= '0;
      end else begin
         state       <= state_nxt;
         drop_err    <= err_nxt;
         drop_ack    <= ack_nxt;
         check_valid <= (state_nxt == CHECK);
         case (state)
            IDLE: begin
               if (drop_req && drop_col != INVALID_COL) begin
                  col_q <= drop_col;
                  row_q <= '0;
               end
            end
            SCAN: begin
               // On an empty cell row_q already holds the landing row.
               if (cell_full && row_q != TOP_ROW) row_q <= row_q + 3'd1;
            end
            WRITE: begin
               onoff_register[cell_idx(col_q, row_q)]  <= 1'b1;
               player_register[cell_idx(col_q, row_q)] <= turn;
               location   <= col_q;
               height     <= row_q;
               player     <= turn;
               move_count <= move_count + 6'd1;
            end
            CHECK: begin
               if (win_valid) begin
                  if (win_in) begin
                     game_over <= 1'b1;
                     winner    <= player;
                  end else if (move_count == MAX_MOVES) begin
                     game_over <= 1'b1;
                     draw      <= 1'b1;
                  end else begin
                     turn <= ~turn;
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_board_drop_ctrl.sv
// tb/tb_board_drop_ctrl.sv - self-checking bench for board_drop_ctrl
module tb_board_drop_ctrl;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        new_game = 1'b0;
   logic        drop_req = 1'b0;
   logic [2:0]  drop_col = 3'd0;
   logic        win_valid = 1'b0;
   logic        win_in = 1'b0;
   logic [41:0] player_register;
   logic [41:0] onoff_register;
   logic [2:0]  location;
   logic [2:0]  height;
   logic        player;
   logic        turn;
   logic        check_valid;
   logic        drop_ack;
   logic        drop_err;
   logic        game_over;
   logic        winner;
   logic        draw;
   logic [5:0]  move_count;

   always #5 clk = ~clk;

   board_drop_ctrl dut (
      .clk             (clk),
      .reset           (reset),
      .new_game        (new_game),
      .drop_req        (drop_req),
      .drop_col        (drop_col),
      .win_valid       (win_valid),
      .win_in          (win_in),
      .player_register (player_register),
      .onoff_register  (onoff_register),
      .location        (location),
      .height          (height),
      .player          (player),
      .turn            (turn),
      .check_valid     (check_valid),
      .drop_ack        (drop_ack),
      .drop_err        (drop_err),
      .game_over       (game_over),
      .winner          (winner),
      .draw            (draw),
      .move_count      (move_count)
   );

   typedef struct {
      logic [2:0] col;
      logic       win;
      logic       exp_err;
      logic [2:0] exp_height;
      logic       exp_player;
      logic       exp_turn;
      logic [5:0] exp_count;
      logic       exp_over;
      logic       exp_draw;
      int         exp_lat;
   } vec_t;

   vec_t        sb[$];
   vec_t        tbl[11];
   int          tests = 0;
   int          failed = 0;
   logic [41:0] m_onoff = '0;
   logic [41:0] m_player = '0;

   function automatic vec_t mk(input logic [2:0] col, input logic win, input logic err,
                               input logic [2:0] h, input logic p, input logic t,
                               input logic [5:0] cnt, input logic over, input logic drw,
                               input int lat);
      vec_t v;
      v.col = col; v.win = win; v.exp_err = err; v.exp_height = h; v.exp_player = p;
      v.exp_turn = t; v.exp_count = cnt; v.exp_over = over; v.exp_draw = drw; v.exp_lat = lat;
      return v;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         failed++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic do_reset();
      reset = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      m_onoff  = '0;
      m_player = '0;
      chk("reset_onoff", 64'(onoff_register), 64'd0);
      chk("reset_player", 64'(player_register), 64'd0);
      chk("reset_flags", {58'd0, turn, game_over, draw, winner, drop_ack, drop_err}, 64'd0);
      chk("reset_count", 64'(move_count), 64'd0);
   endtask

   task automatic check_resp(input int lat);
      vec_t        e;
      logic [5:0]  idx;
      e = sb.pop_front();
      chk("resp_err", 64'(drop_err), 64'(e.exp_err));
      chk("resp_ack", 64'(drop_ack), 64'(!e.exp_err));
      chk("latency", 64'(lat), 64'(e.exp_lat));
      chk("turn", 64'(turn), 64'(e.exp_turn));
      chk("move_count", 64'(move_count), 64'(e.exp_count));
      chk("game_over", 64'(game_over), 64'(e.exp_over));
      chk("draw", 64'(draw), 64'(e.exp_draw));
      if (!e.exp_err) begin
         idx = 6'(int'(e.col) * 6 + int'(e.exp_height));
         m_onoff[idx]  = 1'b1;
         m_player[idx] = e.exp_player;
         chk("location", 64'(location), 64'(e.col));
         chk("height", 64'(height), 64'(e.exp_height));
         chk("player", 64'(player), 64'(e.exp_player));
         if (e.exp_over && !e.exp_draw) chk("winner", 64'(winner), 64'(e.exp_player));
      end
      chk("board_onoff", 64'(onoff_register), 64'(m_onoff));
      chk("board_player", 64'(player_register & onoff_register), 64'(m_player));
   endtask

   task automatic run_vec(input vec_t v);
      int lat;
      bit done;
      bit sent;
      sb.push_back(v);
      @(negedge clk);
      drop_col = v.col;
      drop_req = 1'b1;
      lat = 0; done = 0; sent = 0;
      while (!done && lat < 20) begin
         @(negedge clk);
         lat++;
         drop_req  = 1'b0;
         win_valid = 1'b0;
         if (drop_ack || drop_err) begin
            check_resp(lat);
            done = 1;
         end else if (check_valid && !sent) begin
            win_valid = 1'b1;
            win_in    = sb[0].win;
            sent      = 1;
         end
      end
      win_valid = 1'b0;
      if (!done) begin
         chk("response_timeout", 64'd0, 64'd1);
         void'(sb.pop_front());
      end
      @(negedge clk);
      chk("pulse_clear", {62'd0, drop_ack, drop_err}, 64'd0);
   endtask

   initial begin
      // Single drop: col 3 lands at row 0, ack four cycles after the request.
      do_reset();
      run_vec(mk(3'd3, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1, 6'd1, 1'b0, 1'b0, 4));
      chk("bit18_onoff", 64'(onoff_register[18]), 64'd1);
      chk("bit18_player", 64'(player_register[18]), 64'd0);

      // Column fill, full column, invalid column, win by player 1, request after game over.
      do_reset();
      tbl[0]  = mk(3'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1, 6'd1, 1'b0, 1'b0, 4);
      tbl[1]  = mk(3'd0, 1'b0, 1'b0, 3'd1, 1'b1, 1'b0, 6'd2, 1'b0, 1'b0, 5);
      tbl[2]  = mk(3'd0, 1'b0, 1'b0, 3'd2, 1'b0, 1'b1, 6'd3, 1'b0, 1'b0, 6);
      tbl[3]  = mk(3'd0, 1'b0, 1'b0, 3'd3, 1'b1, 1'b0, 6'd4, 1'b0, 1'b0, 7);
      tbl[4]  = mk(3'd0, 1'b0, 1'b0, 3'd4, 1'b0, 1'b1, 6'd5, 1'b0, 1'b0, 8);
      tbl[5]  = mk(3'd0, 1'b0, 1'b0, 3'd5, 1'b1, 1'b0, 6'd6, 1'b0, 1'b0, 9);
      tbl[6]  = mk(3'd0, 1'b0, 1'b1, 3'd0, 1'b0, 1'b0, 6'd6, 1'b0, 1'b0, 7);
      tbl[7]  = mk(3'd7, 1'b0, 1'b1, 3'd0, 1'b0, 1'b0, 6'd6, 1'b0, 1'b0, 1);
      tbl[8]  = mk(3'd3, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1, 6'd7, 1'b0, 1'b0, 4);
      tbl[9]  = mk(3'd3, 1'b1, 1'b0, 3'd1, 1'b1, 1'b1, 6'd8, 1'b1, 1'b0, 5);
      tbl[10] = mk(3'd2, 1'b0, 1'b1, 3'd0, 1'b0, 1'b1, 6'd8, 1'b1, 1'b0, 1);
      for (int i = 0; i < 11; i++) run_vec(tbl[i]);
      chk("col0_owners", 64'(player_register[5:0]), 64'h2a);
      chk("winner_held", 64'(winner), 64'd1);

      // 42 no-win moves end in a draw.
      do_reset();
      for (int i = 0; i < 42; i++) begin
         run_vec(mk(3'(i / 6), 1'b0, 1'b0, 3'(i % 6), 1'(i % 2),
                    (i == 41) ? 1'b1 : ~1'(i % 2), 6'(i + 1),
                    1'(i == 41), 1'(i == 41), 4 + (i % 6)));
      end
      chk("draw_final", {61'd0, draw, game_over, 1'b0}, 64'd6);
      chk("draw_count", 64'(move_count), 64'd42);

      // new_game while SCAN is examining row 3 leaves no trace of the partial move.
      do_reset();
      run_vec(mk(3'd4, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1, 6'd1, 1'b0, 1'b0, 4));
      run_vec(mk(3'd4, 1'b0, 1'b0, 3'd1, 1'b1, 1'b0, 6'd2, 1'b0, 1'b0, 5));
      run_vec(mk(3'd4, 1'b0, 1'b0, 3'd2, 1'b0, 1'b1, 6'd3, 1'b0, 1'b0, 6));
      @(negedge clk);
      drop_col = 3'd4;
      drop_req = 1'b1;
      @(negedge clk);
      drop_req = 1'b0;
      repeat (3) @(negedge clk);
      new_game = 1'b1;
      @(negedge clk);
      new_game = 1'b0;
      m_onoff  = '0;
      m_player = '0;
      chk("ng_onoff", 64'(onoff_register), 64'd0);
      chk("ng_player", 64'(player_register), 64'd0);
      chk("ng_count", 64'(move_count), 64'd0);
      chk("ng_flags", {60'd0, turn, check_valid, drop_ack, drop_err}, 64'd0);
      run_vec(mk(3'd4, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1, 6'd1, 1'b0, 1'b0, 4));

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout actual=running required=finished");
      $fatal(1, "timeout");
   end

endmodule
